pipe_hazard_sequencer: RTL and testbench
========================================

// Module: pipe_hazard_sequencer
// PURPOSE
//  Sequences the 5-stage RV32 pipeline. Carries main-decoder control bits from ID through EX/MEM/WB.
//  Resolves hazards: load-use stall, branch/jump flush, EX operand forwarding and data-memory wait stalls.
//  Sits between the decoder outputs and the pipeline datapath registers.
//  Also owns a memory-wait watchdog and a saturating bubble counter.
// PARAMETERS
//  MEM_TIMEOUT  16  consecutive mem-wait cycles before err_timeout sets (>=1)
//  CNT_W        32  width of bubble_cnt
// PORTS
//  clk          in   1      pipeline clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  reg_write_d  in   1      decoder RegWrite (ID)
//  mem_write_d  in   1      decoder MemWrite (ID)
//  alu_src_d    in   1      decoder ALUSrc (ID)
//  branch_d     in   1      decoder Branch (ID)
//  jump_d       in   1      decoder Jump (ID)
//  result_src_d in   2      decoder ResultSrc (ID): 00 ALU, 01 MEM, 11 PC+4
//  rs1_d,rs2_d  in   5      source regs (ID)
//  rd_d         in   5      dest reg (ID)
//  zero_e       in   1      ALU zero flag (EX)
//  mem_ready    in   1      data memory done this cycle
//  stall_f      out  1      hold PC
//  stall_d      out  1      hold IF/ID
//  flush_d      out  1      clear IF/ID
//  flush_e      out  1      bubble ID/EX datapath
//  pcsrc_e      out  1      take branch/jump target
//  fwd_a_e      out  2      rs1 mux: 00 regfile, 01 WB result, 10 MEM ALU result
//  fwd_b_e      out  2      rs2 mux, same encoding
//  alu_src_e    out  1      registered EX control
//  mem_write_m  out  1      registered MEM control
//  result_src_w out  2      registered WB control
//  reg_write_w  out  1      registered WB control
//  rd_w         out  5      WB destination
//  err_timeout  out  1      sticky, mem wait exceeded MEM_TIMEOUT
//  bubble_cnt   out  CNT_W  bubbles injected, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - All E/M/W control and reg fields are 0, i.e. bubbles.
//   - All outputs are 0; counter and err_timeout are cleared.
//  Combinational terms:
//   - pcsrc_e = (branch_e & zero_e) | jump_e
//   - lu = result_src_e==01 & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d)
//   - mwait = (mem_write_m | result_src_m==01) & ~mem_ready
//  Forwarding (fwd_a_e shown; fwd_b_e uses rs2_e):
//   - 10 if reg_write_m & rd_m!=0 & rd_m==rs1_e
//   - else 01 if reg_write_w & rd_w!=0 & rd_w==rs1_e
//   - else 00. The MEM stage wins over WB.
//  Priority (highest first):
//   - mwait: stall_f = stall_d = 1, flush_d = flush_e = 0.
//     E and M hold their contents. W loads a bubble (reg_write_w=0).
//     pcsrc_e is still driven but the PC is held; the redirect takes effect once mwait drops.
//   - pcsrc_e: flush_d = flush_e = 1; stalls are 0.
//     E loads a bubble. A coincident lu is ignored.
//   - lu: stall_f = stall_d = 1, flush_e = 1.
//     E loads a bubble for exactly one cycle.
//   - otherwise each stage advances D->E->M->W every cycle.
//  Latency:
//   - Control reaches E one cycle after ID, M after 2 cycles, W after 3 cycles (absent stalls).
//   - Load-use costs 1 bubble; a taken branch/jump costs 2 (D and E flushed).
//  Counter:
//   - bubble_cnt += 1 each cycle E or W is loaded with a bubble by a hazard.
//   - Saturates at all-ones; no wrap.
//  Watchdog:
//   - wait_cnt increments while mwait and clears otherwise.
//   - When wait_cnt reaches MEM_TIMEOUT, err_timeout sets. It clears only on reset.
//   - The pipeline keeps stalling until mem_ready.
//  Reset mid-stall or mid-flush: all state clears immediately; no pending redirect survives.
//  x0 is never a hazard source: no forwarding or stall on rd==0.
// STRUCTURE
//  pipe_ctrl_pkg:
//   - RES_ALU/RES_MEM/RES_PC4 encodings and FWD_RF/FWD_WB/FWD_MEM encodings
//   - ctrl_t struct {reg_write, mem_write, alu_src, branch, jump, result_src, rs1, rs2, rd}
//   - CTRL_BUBBLE constant (all zero)
//  Sub-module ctrl_stage_reg (en, clr, d/q of ctrl_t, async rst_n):
//   - One instance each for E, M and W.
//   - Hazard, forward, watchdog and counter logic stays in the top.
// TESTING
//  1. lw x5 in E, ID add rs1=x5 -> stall_f=stall_d=flush_e=1 for 1 cycle;
//     next cycle fwd_a_e=01; bubble_cnt=1.
//  2. add x3 in M, add x3 in W, EX rs1=x3 -> fwd_a_e=10.
//     Same case with rd=x0 -> fwd_a_e=00.
//  3. beq in E with zero_e=1 -> pcsrc_e=flush_d=flush_e=1, E bubble.
//     With zero_e=0 -> no flush.
//     jal in E -> pcsrc_e=1 regardless of zero_e.
//  4. sw in M, mem_ready=0 for 3 cycles -> stall_f/d=1 for 3 cycles, E/M held, reg_write_w=0.
//     Flushes are masked even with a taken beq in E; pcsrc_e=1 and the redirect completes after mem_ready=1.
//  5. mem_ready=0 for MEM_TIMEOUT cycles -> err_timeout=1 and stays 1 after mem_ready=1.
//     rst_n=0 -> all outputs 0 asynchronously (checked between clock edges).
//  6. Force bubble_cnt to all-ones - 1, inject 3 bubbles -> counter holds at all-ones.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared control-word type, result/forward encodings and the forwarding-select
// helper for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b11;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [1:0] result_src;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // The MEM-stage producer is younger than WB, so it wins; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       m_rw,
                                         input logic [4:0] m_rd,
                                         input logic       w_rw,
                                         input logic [4:0] w_rd);
    if (m_rw && (m_rd != 5'd0) && (m_rd == rs)) return FWD_MEM;
    if (w_rw && (w_rd != 5'd0) && (w_rd == rs)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_sequencer_if.sv
// Decoder-side inputs and hazard/pipeline-control outputs of the sequencer.
// The master side is the decoder/datapath, the slave side is the sequencer.
interface pipe_hazard_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             reg_write_d;
  logic             mem_write_d;
  logic             alu_src_d;
  logic             branch_d;
  logic             jump_d;
  logic [1:0]       result_src_d;
  logic [4:0]       rs1_d;
  logic [4:0]       rs2_d;
  logic [4:0]       rd_d;
  logic             zero_e;
  logic             mem_ready;

  logic             stall_f;
  logic             stall_d;
  logic             flush_d;
  logic             flush_e;
  logic             pcsrc_e;
  logic [1:0]       fwd_a_e;
  logic [1:0]       fwd_b_e;
  logic             alu_src_e;
  logic             mem_write_m;
  logic [1:0]       result_src_w;
  logic             reg_write_w;
  logic [4:0]       rd_w;
  logic             err_timeout;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output reg_write_d, mem_write_d, alu_src_d, branch_d, jump_d,
    output result_src_d, rs1_d, rs2_d, rd_d, zero_e, mem_ready,
    input  stall_f, stall_d, flush_d, flush_e, pcsrc_e,
    input  fwd_a_e, fwd_b_e, alu_src_e, mem_write_m,
    input  result_src_w, reg_write_w, rd_w, err_timeout, bubble_cnt
  );

  modport slave (
    input  reg_write_d, mem_write_d, alu_src_d, branch_d, jump_d,
    input  result_src_d, rs1_d, rs2_d, rd_d, zero_e, mem_ready,
    output stall_f, stall_d, flush_d, flush_e, pcsrc_e,
    output fwd_a_e, fwd_b_e, alu_src_e, mem_write_m,
    output result_src_w, reg_write_w, rd_w, err_timeout, bubble_cnt
  );

endinterface

// File: rtl/ctrl_stage_reg.sv
// One pipeline control-word register: clear (bubble) beats enable (advance),
// disabled means hold.
module ctrl_stage_reg
  import pipe_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_en,
  input  logic  i_clr,
  input  ctrl_t i_d,
  output ctrl_t o_q
);

  ctrl_t r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= CTRL_BUBBLE;
    end else if (i_clr) begin
      r_q <= CTRL_BUBBLE;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// Carries decoder control through E/M/W and resolves load-use, branch/jump,
// forwarding and data-memory wait hazards; also a mem-wait watchdog and bubble counter.
module pipe_hazard_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipe_hazard_sequencer_if.slave  bus
);

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  ctrl_t w_ctrl_d;
  ctrl_t w_ctrl_e;
  ctrl_t w_ctrl_m;
  ctrl_t w_ctrl_w;

  logic w_pcsrc;
  logic w_lu;
  logic w_mwait;
  logic w_e_clr;
  logic w_adv;
  logic w_bubble;

  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_err_timeout;
  logic [CNT_W-1:0]  r_bubble_cnt;

  assign w_ctrl_d = '{reg_write:  bus.reg_write_d,
                      mem_write:  bus.mem_write_d,
                      alu_src:    bus.alu_src_d,
                      branch:     bus.branch_d,
                      jump:       bus.jump_d,
                      result_src: bus.result_src_d,
                      rs1:        bus.rs1_d,
                      rs2:        bus.rs2_d,
                      rd:         bus.rd_d};

  // Hazard detection
  assign w_pcsrc = (w_ctrl_e.branch & bus.zero_e) | w_ctrl_e.jump;
  assign w_lu    = (w_ctrl_e.result_src == RES_MEM) && (w_ctrl_e.rd != 5'd0) &&
                   ((w_ctrl_e.rd == bus.rs1_d) || (w_ctrl_e.rd == bus.rs2_d));
  assign w_mwait = (w_ctrl_m.mem_write | (w_ctrl_m.result_src == RES_MEM)) & ~bus.mem_ready;

  // A memory wait freezes E and M and drains W; it masks both flush and load-use.
  assign w_adv    = ~w_mwait;
  assign w_e_clr  = w_adv & (w_pcsrc | w_lu);
  assign w_bubble = w_mwait | w_pcsrc | w_lu;

  ctrl_stage_reg u_stage_e (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_adv),
    .i_clr (w_e_clr),
    .i_d   (w_ctrl_d),
    .o_q   (w_ctrl_e)
  );

  ctrl_stage_reg u_stage_m (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_adv),
    .i_clr (1'b0),
    .i_d   (w_ctrl_e),
    .o_q   (w_ctrl_m)
  );

  ctrl_stage_reg u_stage_w (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (1'b1),
    .i_clr (w_mwait),
    .i_d   (w_ctrl_m),
    .o_q   (w_ctrl_w)
  );

  // Watchdog: err sets on the edge where the consecutive-wait count reaches MEM_TIMEOUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt    <= '0;
      r_err_timeout <= 1'b0;
    end else if (w_mwait) begin
      if (r_wait_cnt != WAIT_MAX) r_wait_cnt <= r_wait_cnt + 1'b1;
      if (r_wait_cnt >= (WAIT_MAX - 1'b1)) r_err_timeout <= 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble) begin
      r_bubble_cnt <= sat_inc(r_bubble_cnt);
    end
  end

  assign bus.stall_f      = w_mwait | (w_lu & ~w_pcsrc);
  assign bus.stall_d      = w_mwait | (w_lu & ~w_pcsrc);
  assign bus.flush_d      = w_adv & w_pcsrc;
  assign bus.flush_e      = w_e_clr;
  assign bus.pcsrc_e      = w_pcsrc;
  assign bus.fwd_a_e      = fwd_sel(w_ctrl_e.rs1, w_ctrl_m.reg_write, w_ctrl_m.rd,
                                    w_ctrl_w.reg_write, w_ctrl_w.rd);
  assign bus.fwd_b_e      = fwd_sel(w_ctrl_e.rs2, w_ctrl_m.reg_write, w_ctrl_m.rd,
                                    w_ctrl_w.reg_write, w_ctrl_w.rd);
  assign bus.alu_src_e    = w_ctrl_e.alu_src;
  assign bus.mem_write_m  = w_ctrl_m.mem_write;
  assign bus.result_src_w = w_ctrl_w.result_src;
  assign bus.reg_write_w  = w_ctrl_w.reg_write;
  assign bus.rd_w         = w_ctrl_w.rd;
  assign bus.err_timeout  = r_err_timeout;
  assign bus.bubble_cnt   = r_bubble_cnt;

  // W only exposes writeback fields; the rest of its control word is dead.
  logic w_unused_w;
  assign w_unused_w = ^{w_ctrl_w.mem_write, w_ctrl_w.alu_src, w_ctrl_w.branch,
                        w_ctrl_w.jump, w_ctrl_w.rs1, w_ctrl_w.rs2};

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Directed bench for pipe_hazard_sequencer: a per-cycle vector table plus
// hand-written memory-wait, watchdog, async-reset and saturation sequences.
module tb_pipe_hazard_sequencer;
  import pipe_ctrl_pkg::*;

  localparam int MT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_sequencer_if #(.CNT_W(32)) bus ();
  pipe_hazard_sequencer_if #(.CNT_W(2))  sif ();

  pipe_hazard_sequencer #(.MEM_TIMEOUT(MT), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pipe_hazard_sequencer #(.MEM_TIMEOUT(MT), .CNT_W(2)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  typedef struct {
    ctrl_t       d;
    logic        z;
    logic        st;
    logic        fd;
    logic        fe;
    logic        pc;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        rww;
    logic [4:0]  rdw;
    logic [1:0]  rsw;
    int          cnt;
  } vec_t;

  vec_t tv[$];

  function automatic ctrl_t f_nop();
    return CTRL_BUBBLE;
  endfunction

  function automatic ctrl_t f_add(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    ctrl_t c = CTRL_BUBBLE;
    c.reg_write = 1'b1; c.rd = rd; c.rs1 = a; c.rs2 = b;
    return c;
  endfunction

  function automatic ctrl_t f_lw(input logic [4:0] rd, input logic [4:0] a);
    ctrl_t c = CTRL_BUBBLE;
    c.reg_write = 1'b1; c.alu_src = 1'b1; c.result_src = RES_MEM; c.rd = rd; c.rs1 = a;
    return c;
  endfunction

  function automatic ctrl_t f_sw(input logic [4:0] a, input logic [4:0] b);
    ctrl_t c = CTRL_BUBBLE;
    c.mem_write = 1'b1; c.alu_src = 1'b1; c.rs1 = a; c.rs2 = b;
    return c;
  endfunction

  function automatic ctrl_t f_beq(input logic [4:0] a, input logic [4:0] b);
    ctrl_t c = CTRL_BUBBLE;
    c.branch = 1'b1; c.rs1 = a; c.rs2 = b;
    return c;
  endfunction

  function automatic ctrl_t f_jal(input logic [4:0] rd);
    ctrl_t c = CTRL_BUBBLE;
    c.jump = 1'b1; c.reg_write = 1'b1; c.result_src = RES_PC4; c.rd = rd;
    return c;
  endfunction

  function automatic vec_t mk(input ctrl_t d, input logic z, input logic st, input logic fd,
                              input logic fe, input logic pc, input logic [1:0] fa,
                              input logic [1:0] fb, input logic rww, input logic [4:0] rdw,
                              input logic [1:0] rsw, input int cnt);
    vec_t v;
    v.d = d; v.z = z; v.st = st; v.fd = fd; v.fe = fe; v.pc = pc;
    v.fa = fa; v.fb = fb; v.rww = rww; v.rdw = rdw; v.rsw = rsw; v.cnt = cnt;
    return v;
  endfunction

  task automatic drive(input ctrl_t c, input logic z, input logic rdy);
    bus.reg_write_d  = c.reg_write;
    bus.mem_write_d  = c.mem_write;
    bus.alu_src_d    = c.alu_src;
    bus.branch_d     = c.branch;
    bus.jump_d       = c.jump;
    bus.result_src_d = c.result_src;
    bus.rs1_d        = c.rs1;
    bus.rs2_d        = c.rs2;
    bus.rd_d         = c.rd;
    bus.zero_e       = z;
    bus.mem_ready    = rdy;
  endtask

  task automatic sdrive(input ctrl_t c, input logic rdy);
    sif.reg_write_d  = c.reg_write;
    sif.mem_write_d  = c.mem_write;
    sif.alu_src_d    = c.alu_src;
    sif.branch_d     = c.branch;
    sif.jump_d       = c.jump;
    sif.result_src_d = c.result_src;
    sif.rs1_d        = c.rs1;
    sif.rs2_d        = c.rs2;
    sif.rd_d         = c.rd;
    sif.zero_e       = 1'b0;
    sif.mem_ready    = rdy;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".stall_f"},      32'(bus.stall_f),      32'd0);
    chk({tag, ".stall_d"},      32'(bus.stall_d),      32'd0);
    chk({tag, ".flush_d"},      32'(bus.flush_d),      32'd0);
    chk({tag, ".flush_e"},      32'(bus.flush_e),      32'd0);
    chk({tag, ".pcsrc_e"},      32'(bus.pcsrc_e),      32'd0);
    chk({tag, ".fwd_a_e"},      32'(bus.fwd_a_e),      32'd0);
    chk({tag, ".fwd_b_e"},      32'(bus.fwd_b_e),      32'd0);
    chk({tag, ".alu_src_e"},    32'(bus.alu_src_e),    32'd0);
    chk({tag, ".mem_write_m"},  32'(bus.mem_write_m),  32'd0);
    chk({tag, ".result_src_w"}, 32'(bus.result_src_w), 32'd0);
    chk({tag, ".reg_write_w"},  32'(bus.reg_write_w),  32'd0);
    chk({tag, ".rd_w"},         32'(bus.rd_w),         32'd0);
    chk({tag, ".err_timeout"},  32'(bus.err_timeout),  32'd0);
    chk({tag, ".bubble_cnt"},   bus.bubble_cnt,        32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    drive(f_nop(), 1'b0, 1'b1);
    sdrive(f_nop(), 1'b1);

    // Per-cycle table: inputs in ID and the outputs expected before that cycle's edge.
    //               D                 z  st fd fe pc fa     fb     rww rdw    rsw    cnt
    tv.push_back(mk(f_lw(5, 1),        0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 5'd0,  2'b00, 0));
    tv.push_back(mk(f_add(6, 5, 2),    0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 5'd0,  2'b00, 0));
    tv.push_back(mk(f_add(6, 5, 2),    0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 5'd0,  2'b00, 1));
    tv.push_back(mk(f_nop(),           0, 0, 0, 0, 0, 2'b01, 2'b00, 1, 5'd5,  2'b01, 1));
    tv.push_back(mk(f_add(3, 0, 0),    0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 5'd0,  2'b00, 1));
    tv.push_back(mk(f_add(3, 1, 1),    0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 5'd6,  2'b00, 1));
    tv.push_back(mk(f_add(7, 3, 3),    0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 5'd0,  2'b00, 1));
    tv.push_back(mk(f_nop(),           0, 0, 0, 0, 0, 2'b10, 2'b10, 1, 5'd3,  2'b00, 1));
    tv.push_back(mk(f_add(0, 1, 1),    0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 5'd3,  2'b00, 1));
    tv.push_back(mk(f_add(8, 0, 0),    0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 5'd7,  2'b00, 1));
    tv.push_back(mk(f_nop(),           0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 5'd0,  2'b00, 1));
    tv.push_back(mk(f_beq(1, 2),       0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 5'd0,  2'b00, 1));
    tv.push_back(mk(f_add(9, 1, 2),    0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 5'd8,  2'b00, 1));
    tv.push_back(mk(f_beq(1, 2),       0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 5'd0,  2'b00, 1));
    tv.push_back(mk(f_add(10, 1, 2),   1, 0, 1, 1, 1, 2'b00, 2'b00, 0, 5'd0,  2'b00, 1));
    tv.push_back(mk(f_jal(1),          0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 5'd9,  2'b00, 2));
    tv.push_back(mk(f_add(11, 1, 2),   0, 0, 1, 1, 1, 2'b00, 2'b00, 0, 5'd0,  2'b00, 2));
    tv.push_back(mk(f_nop(),           0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 5'd0,  2'b00, 3));
    tv.push_back(mk(f_nop(),           0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 5'd1,  2'b11, 3));

    repeat (2) @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      drive(tv[i].d, tv[i].z, 1'b1);
      #1;
      chk($sformatf("r%0d.stall_f", i),      32'(bus.stall_f),      32'(tv[i].st));
      chk($sformatf("r%0d.stall_d", i),      32'(bus.stall_d),      32'(tv[i].st));
      chk($sformatf("r%0d.flush_d", i),      32'(bus.flush_d),      32'(tv[i].fd));
      chk($sformatf("r%0d.flush_e", i),      32'(bus.flush_e),      32'(tv[i].fe));
      chk($sformatf("r%0d.pcsrc_e", i),      32'(bus.pcsrc_e),      32'(tv[i].pc));
      chk($sformatf("r%0d.fwd_a_e", i),      32'(bus.fwd_a_e),      32'(tv[i].fa));
      chk($sformatf("r%0d.fwd_b_e", i),      32'(bus.fwd_b_e),      32'(tv[i].fb));
      chk($sformatf("r%0d.reg_write_w", i),  32'(bus.reg_write_w),  32'(tv[i].rww));
      chk($sformatf("r%0d.rd_w", i),         32'(bus.rd_w),         32'(tv[i].rdw));
      chk($sformatf("r%0d.result_src_w", i), 32'(bus.result_src_w), 32'(tv[i].rsw));
      chk($sformatf("r%0d.bubble_cnt", i),   bus.bubble_cnt,        32'(tv[i].cnt));
      @(negedge clk);
    end

    // sw reaches M, then a taken beq sits in E while memory waits 3 cycles
    drive(f_sw(1, 2), 1'b0, 1'b1);
    @(negedge clk);
    drive(f_beq(1, 2), 1'b0, 1'b1);
    #1 chk("mw.alu_src_e_sw", 32'(bus.alu_src_e), 32'd1);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      drive(f_add(12, 1, 2), 1'b1, 1'b0);
      #1;
      chk($sformatf("mw%0d.stall_f", k),     32'(bus.stall_f),     32'd1);
      chk($sformatf("mw%0d.stall_d", k),     32'(bus.stall_d),     32'd1);
      chk($sformatf("mw%0d.flush_d", k),     32'(bus.flush_d),     32'd0);
      chk($sformatf("mw%0d.flush_e", k),     32'(bus.flush_e),     32'd0);
      chk($sformatf("mw%0d.pcsrc_e", k),     32'(bus.pcsrc_e),     32'd1);
      chk($sformatf("mw%0d.mem_write_m", k), 32'(bus.mem_write_m), 32'd1);
      chk($sformatf("mw%0d.reg_write_w", k), 32'(bus.reg_write_w), 32'd0);
      chk($sformatf("mw%0d.bubble_cnt", k),  bus.bubble_cnt,       32'(3 + k));
      @(negedge clk);
    end
    drive(f_add(12, 1, 2), 1'b1, 1'b1);
    #1;
    chk("mwdone.stall_f", 32'(bus.stall_f), 32'd0);
    chk("mwdone.flush_d", 32'(bus.flush_d), 32'd1);
    chk("mwdone.flush_e", 32'(bus.flush_e), 32'd1);
    chk("mwdone.pcsrc_e", 32'(bus.pcsrc_e), 32'd1);
    chk("mwdone.bubble_cnt", bus.bubble_cnt, 32'd6);
    @(negedge clk);
    drive(f_nop(), 1'b0, 1'b1);
    #1;
    chk("post.pcsrc_e",     32'(bus.pcsrc_e),     32'd0);
    chk("post.flush_e",     32'(bus.flush_e),     32'd0);
    chk("post.alu_src_e",   32'(bus.alu_src_e),   32'd0);
    chk("post.mem_write_m", 32'(bus.mem_write_m), 32'd0);
    chk("post.reg_write_w", 32'(bus.reg_write_w), 32'd0);
    chk("post.bubble_cnt",  bus.bubble_cnt,       32'd7);
    @(negedge clk);

    // lw stuck in M for MT cycles trips the sticky watchdog
    drive(f_lw(13, 1), 1'b0, 1'b1);
    @(negedge clk);
    drive(f_nop(), 1'b0, 1'b1);
    #1 chk("to.no_lu_stall", 32'(bus.stall_f), 32'd0);
    @(negedge clk);
    for (int k = 0; k < MT; k++) begin
      drive(f_nop(), 1'b0, 1'b0);
      #1;
      chk($sformatf("to%0d.err_timeout", k), 32'(bus.err_timeout), 32'(k >= MT));
      chk($sformatf("to%0d.stall_f", k),     32'(bus.stall_f),     32'd1);
      @(negedge clk);
    end
    #1;
    chk("to.err_set",  32'(bus.err_timeout), 32'd1);
    chk("to.stalling", 32'(bus.stall_d),     32'd1);
    drive(f_nop(), 1'b0, 1'b1);
    #1;
    chk("to.ready_stall", 32'(bus.stall_f),     32'd0);
    chk("to.err_hold0",   32'(bus.err_timeout), 32'd1);
    @(negedge clk);
    #1 chk("to.err_hold1", 32'(bus.err_timeout), 32'd1);

    // Async reset while a jal is redirecting from E
    drive(f_jal(1), 1'b0, 1'b1);
    @(negedge clk);
    drive(f_nop(), 1'b0, 1'b1);
    #1 chk("rst.pre_pcsrc", 32'(bus.pcsrc_e), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst.no_redirect0", 32'(bus.pcsrc_e), 32'd0);
    @(negedge clk);
    #1;
    chk("rst.no_redirect1", 32'(bus.pcsrc_e),  32'd0);
    chk("rst.flush_d",      32'(bus.flush_d),  32'd0);
    chk("rst.bubble_cnt",   bus.bubble_cnt,    32'd0);

    // 2-bit counter instance: memory-wait bubbles saturate at 3
    sdrive(f_sw(1, 2), 1'b1);
    @(negedge clk);
    sdrive(f_nop(), 1'b1);
    @(negedge clk);
    #1 chk("sat.start", 32'(sif.bubble_cnt), 32'd0);
    sdrive(f_nop(), 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      #1 chk($sformatf("sat%0d.bubble_cnt", k), 32'(sif.bubble_cnt), 32'((k < 3) ? k : 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
